// File: rtl/qam_symbol_mapper_pkg.sv
// rtl/qam_symbol_mapper_pkg.sv - wimax_mod_pkg: mapper modes, bps lookup, amplitude helpers
// Accumulator width follows QAM_MAPPER_16QAM_EN (4 bits with 16QAM, 2 without).
package wimax_mod_pkg;

  typedef enum logic [1:0] {
    MODE_BPSK  = 2'd0,
    MODE_QPSK  = 2'd1,
    MODE_16QAM = 2'd2,
    MODE_RSVD  = 2'd3
  } mod_mode_e;

`ifdef QAM_MAPPER_16QAM_EN
  localparam int ACC_W = 4;
`else
  localparam int ACC_W = 2;
`endif

  localparam int IQ_W_DEF = 16;

  typedef struct packed {
    logic signed [IQ_W_DEF-1:0] i;
    logic signed [IQ_W_DEF-1:0] q;
  } iq_t;

  function automatic logic mode_supported(logic [1:0] m);
    logic ok;
    ok = (m == MODE_BPSK) || (m == MODE_QPSK);
`ifdef QAM_MAPPER_16QAM_EN
    ok = ok || (m == MODE_16QAM);
`endif
    return ok;
  endfunction

  // Unsupported requests fall back to QPSK mapping.
  function automatic mod_mode_e mode_decode(logic [1:0] m);
    return mode_supported(m) ? mod_mode_e'(m) : MODE_QPSK;
  endfunction

  function automatic logic [2:0] bps_of(mod_mode_e m);
    logic [2:0] n;
    case (m)
      MODE_BPSK:  n = 3'd1;
`ifdef QAM_MAPPER_16QAM_EN
      MODE_16QAM: n = 3'd4;
`endif
      default:    n = 3'd2;
    endcase
    return n;
  endfunction

  function automatic int amp_full(int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // round(2^(w-1) / sqrt(d)) using an integer square root of 2^(2w-2)/d.
  function automatic int amp_div(int w, int d);
    longint n;
    longint t;
    longint f;
    longint c;
    n = longint'(1) << (2 * (w - 1));
    t = n / d;
    f = 0;
    for (int b = 30; b >= 0; b--) begin
      c = f | (longint'(1) << b);
      if (c * c <= t) f = c;
    end
    if ((2 * f + 1) * (2 * f + 1) * d < 4 * n) f = f + 1;
    return int'(f);
  endfunction

endpackage

// File: rtl/qam_symbol_mapper_if.sv
// rtl/qam_symbol_mapper_if.sv - serial bit input stream and I/Q symbol output stream
interface qam_symbol_mapper_if #(
  parameter int IQ_W = 16
) ();
  logic                   in_valid;
  logic                   in_bit;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [IQ_W-1:0] out_i;
  logic signed [IQ_W-1:0] out_q;
  logic                   out_last;

  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_i, out_q, out_last
  );

  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_i, out_q, out_last
  );
endinterface

// File: rtl/qam_level_lut.sv
// rtl/qam_level_lut.sv - combinational {mode, bits} to I/Q constellation levels
// 16QAM levels exist only when QAM_MAPPER_16QAM_EN is defined.
module qam_level_lut
  import wimax_mod_pkg::*;
#(
  parameter int IQ_W = 16
) (
  input  mod_mode_e              mode,
  input  logic [ACC_W-1:0]       bits,
  output logic signed [IQ_W-1:0] lvl_i,
  output logic signed [IQ_W-1:0] lvl_q
);
  localparam logic signed [IQ_W-1:0] A1 = IQ_W'(amp_full(IQ_W));
  localparam logic signed [IQ_W-1:0] A2 = IQ_W'(amp_div(IQ_W, 2));
`ifdef QAM_MAPPER_16QAM_EN
  localparam logic signed [IQ_W-1:0] A3I = IQ_W'(amp_div(IQ_W, 10));
  localparam logic signed [IQ_W-1:0] A3O = IQ_W'(3 * amp_div(IQ_W, 10));
`endif

  // Bit value 0 maps to the positive level, 1 to its two's complement.
  always_comb begin
    lvl_i = bits[0] ? -A2 : A2;
    lvl_q = bits[1] ? -A2 : A2;
    case (mode)
      MODE_BPSK: begin
        lvl_i = bits[0] ? -A1 : A1;
        lvl_q = '0;
      end
`ifdef QAM_MAPPER_16QAM_EN
      MODE_16QAM: begin
        lvl_i = bits[0] ? (bits[1] ? -A3O : -A3I) : (bits[1] ? A3O : A3I);
        lvl_q = bits[2] ? (bits[3] ? -A3O : -A3I) : (bits[3] ? A3O : A3I);
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: rtl/qam_symbol_mapper.sv
// rtl/qam_symbol_mapper.sv - serial bits to BPSK/QPSK/16QAM I/Q symbols with FEC-block tracking
// 16QAM support is built in when QAM_MAPPER_16QAM_EN is defined.
module qam_symbol_mapper
  import wimax_mod_pkg::*;
#(
  parameter int IQ_W       = 16,
  parameter int BLOCK_BITS = 192
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        mode,
  output logic              mode_err,
  qam_symbol_mapper_if.slave bus
);
  localparam int BLK_W = $clog2(BLOCK_BITS);
  localparam int SYM_W = (ACC_W == 4) ? 2 : 1;

  mod_mode_e              mode_q;
  mod_mode_e              cur_mode;
  logic [BLK_W-1:0]       blk_cnt;
  logic [SYM_W-1:0]       sym_cnt;
  logic [ACC_W-1:0]       acc;
  logic [ACC_W-1:0]       acc_next;
  logic                   accept;
  logic                   block_start;
  logic                   sym_done;
  logic signed [IQ_W-1:0] lvl_i;
  logic signed [IQ_W-1:0] lvl_q;
  logic signed [IQ_W-1:0] out_i_q;
  logic signed [IQ_W-1:0] out_q_q;
  logic                   out_valid_q;
  logic                   out_last_q;

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_i     = out_i_q;
  assign bus.out_q     = out_q_q;
  assign bus.out_last  = out_last_q;

  assign accept      = bus.in_valid && bus.in_ready;
  assign block_start = (blk_cnt == '0);
  // The first bit of a block already maps with the freshly requested mode.
  assign cur_mode    = block_start ? mode_decode(mode) : mode_q;
  assign sym_done    = (3'(sym_cnt) == (bps_of(cur_mode) - 3'd1));

  always_comb begin
    acc_next          = acc;
    acc_next[sym_cnt] = bus.in_bit;
  end

  qam_level_lut #(.IQ_W(IQ_W)) u_lut (
    .mode  (cur_mode),
    .bits  (acc_next),
    .lvl_i (lvl_i),
    .lvl_q (lvl_q)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q      <= MODE_QPSK;
      blk_cnt     <= '0;
      sym_cnt     <= '0;
      acc         <= '0;
      out_valid_q <= 1'b0;
      out_i_q     <= '0;
      out_q_q     <= '0;
      out_last_q  <= 1'b0;
      mode_err    <= 1'b0;
    end else begin
      mode_err <= 1'b0;
      if (bus.out_ready) out_valid_q <= 1'b0;
      if (accept) begin
        if (block_start) begin
          mode_q   <= cur_mode;
          mode_err <= !mode_supported(mode);
        end
        blk_cnt <= (blk_cnt == BLK_W'(BLOCK_BITS - 1)) ? '0 : blk_cnt + BLK_W'(1);
        // A completing symbol overrides the retire above: no bubble.
        if (sym_done) begin
          acc         <= '0;
          sym_cnt     <= '0;
          out_valid_q <= 1'b1;
          out_i_q     <= lvl_i;
          out_q_q     <= lvl_q;
          out_last_q  <= (blk_cnt == BLK_W'(BLOCK_BITS - 1));
        end else begin
          acc     <= acc_next;
          sym_cnt <= sym_cnt + SYM_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_qam_symbol_mapper.sv
// tb/tb_qam_symbol_mapper.sv - directed self-checking bench for qam_symbol_mapper
// 16QAM scenario follows QAM_MAPPER_16QAM_EN; otherwise mode 2 is checked as reserved.
module tb_qam_symbol_mapper;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] mode = 2'd1;
  logic       mode_err;
  int         total = 0;
  int         bad = 0;

  qam_symbol_mapper_if #(.IQ_W(16)) bus ();

  qam_symbol_mapper #(.IQ_W(16), .BLOCK_BITS(192)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .mode     (mode),
    .mode_err (mode_err),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bit = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Drive one bit from a negedge, return on the negedge after it was accepted.
  task automatic send_bit(input logic b);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_bit = b;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL send_bit_timeout in_ready=%b required 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b1;
    do_reset();
    total += 6;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus.out_valid); end
    if (bus.out_i !== 16'h0000) begin bad++; $display("FAIL rst_i got=%h exp=0000", bus.out_i); end
    if (bus.out_q !== 16'h0000) begin bad++; $display("FAIL rst_q got=%h exp=0000", bus.out_q); end
    if (bus.out_last !== 1'b0) begin bad++; $display("FAIL rst_last got=%b exp=0", bus.out_last); end
    if (mode_err !== 1'b0) begin bad++; $display("FAIL rst_mode_err got=%b exp=0", mode_err); end
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_qpsk();
    do_reset();
    mode = 2'd1;
    bus.out_ready = 1'b1;
    send_bit(1'b0);
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL qpsk_half got=%b exp=0", bus.out_valid); end
    send_bit(1'b1);
    total += 4;
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL qpsk1_valid got=%b exp=1", bus.out_valid); end
    if (bus.out_i !== 16'h5A82) begin bad++; $display("FAIL qpsk1_i got=%h exp=5a82", bus.out_i); end
    if (bus.out_q !== 16'hA57E) begin bad++; $display("FAIL qpsk1_q got=%h exp=a57e", bus.out_q); end
    if (mode_err !== 1'b0) begin bad++; $display("FAIL qpsk_mode_err got=%b exp=0", mode_err); end
    send_bit(1'b1);
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL qpsk_retire got=%b exp=0", bus.out_valid); end
    send_bit(1'b1);
    total += 3;
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL qpsk2_valid got=%b exp=1", bus.out_valid); end
    if (bus.out_i !== 16'hA57E) begin bad++; $display("FAIL qpsk2_i got=%h exp=a57e", bus.out_i); end
    if (bus.out_q !== 16'hA57E) begin bad++; $display("FAIL qpsk2_q got=%h exp=a57e", bus.out_q); end
  endtask

  task automatic test_bpsk_block();
    do_reset();
    mode = 2'd0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 192; k++) begin
      send_bit(k[0]);
      total += 4;
      if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bpsk_valid k=%0d got=%b exp=1", k, bus.out_valid); end
      if (bus.out_i !== (k[0] ? 16'h8001 : 16'h7FFF))
        begin bad++; $display("FAIL bpsk_i k=%0d got=%h exp=%h", k, bus.out_i, k[0] ? 16'h8001 : 16'h7FFF); end
      if (bus.out_q !== 16'h0000) begin bad++; $display("FAIL bpsk_q k=%0d got=%h exp=0000", k, bus.out_q); end
      if (bus.out_last !== (k == 191)) begin bad++; $display("FAIL bpsk_last k=%0d got=%b exp=%b", k, bus.out_last, k == 191); end
    end
    mode = 2'd1;
    send_bit(1'b0);
    send_bit(1'b0);
    total += 4;
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid got=%b exp=1", bus.out_valid); end
    if (bus.out_i !== 16'h5A82) begin bad++; $display("FAIL wrap_i got=%h exp=5a82", bus.out_i); end
    if (bus.out_q !== 16'h5A82) begin bad++; $display("FAIL wrap_q got=%h exp=5a82", bus.out_q); end
    if (bus.out_last !== 1'b0) begin bad++; $display("FAIL wrap_last got=%b exp=0", bus.out_last); end
  endtask

  task automatic test_16qam();
    do_reset();
    mode = 2'd2;
    bus.out_ready = 1'b1;
`ifdef QAM_MAPPER_16QAM_EN
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL qam_partial got=%b exp=0", bus.out_valid); end
    send_bit(1'b0);
    total += 4;
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL qam_valid got=%b exp=1", bus.out_valid); end
    if (bus.out_i !== 16'h796E) begin bad++; $display("FAIL qam_i got=%h exp=796e", bus.out_i); end
    if (bus.out_q !== 16'hD786) begin bad++; $display("FAIL qam_q got=%h exp=d786", bus.out_q); end
    if (mode_err !== 1'b0) begin bad++; $display("FAIL qam_mode_err got=%b exp=0", mode_err); end
    for (int s = 1; s < 48; s++) begin
      for (int b = 0; b < 4; b++) send_bit(1'b0);
      total += 2;
      if (bus.out_i !== 16'h287A) begin bad++; $display("FAIL qam_inner s=%0d got=%h exp=287a", s, bus.out_i); end
      if (bus.out_last !== (s == 47)) begin bad++; $display("FAIL qam_last s=%0d got=%b exp=%b", s, bus.out_last, s == 47); end
    end
`else
    send_bit(1'b0);
    total++;
    if (mode_err !== 1'b1) begin bad++; $display("FAIL m2_mode_err got=%b exp=1", mode_err); end
    send_bit(1'b1);
    total += 4;
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL m2_valid got=%b exp=1", bus.out_valid); end
    if (bus.out_i !== 16'h5A82) begin bad++; $display("FAIL m2_i got=%h exp=5a82", bus.out_i); end
    if (bus.out_q !== 16'hA57E) begin bad++; $display("FAIL m2_q got=%h exp=a57e", bus.out_q); end
    if (mode_err !== 1'b0) begin bad++; $display("FAIL m2_err_pulse got=%b exp=0", mode_err); end
`endif
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 2'd1;
    bus.out_ready = 1'b0;
    send_bit(1'b1);
    send_bit(1'b0);
    bus.in_valid = 1'b1;
    bus.in_bit = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total += 4;
      if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready c=%0d got=%b exp=0", c, bus.in_ready); end
      if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid c=%0d got=%b exp=1", c, bus.out_valid); end
      if (bus.out_i !== 16'hA57E) begin bad++; $display("FAIL bp_i c=%0d got=%h exp=a57e", c, bus.out_i); end
      if (bus.out_q !== 16'h5A82) begin bad++; $display("FAIL bp_q c=%0d got=%h exp=5a82", c, bus.out_q); end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b exp=0", bus.out_valid); end
    send_bit(1'b1);
    total += 3;
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_next_valid got=%b exp=1", bus.out_valid); end
    if (bus.out_i !== 16'h5A82) begin bad++; $display("FAIL bp_next_i got=%h exp=5a82", bus.out_i); end
    if (bus.out_q !== 16'hA57E) begin bad++; $display("FAIL bp_next_q got=%h exp=a57e", bus.out_q); end
  endtask

  task automatic test_mode_switch();
    do_reset();
    mode = 2'd1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 192; k++) begin
      if (k == 2) mode = 2'd0;
      send_bit(k[1]);
      total++;
      if (bus.out_valid !== k[0]) begin bad++; $display("FAIL sw_valid k=%0d got=%b exp=%b", k, bus.out_valid, k[0]); end
      if (k[0]) begin
        total++;
        if (bus.out_last !== (k == 191)) begin bad++; $display("FAIL sw_last k=%0d got=%b exp=%b", k, bus.out_last, k == 191); end
      end
      if (k == 3) begin
        total += 2;
        if (bus.out_i !== 16'hA57E) begin bad++; $display("FAIL sw_i got=%h exp=a57e", bus.out_i); end
        if (bus.out_q !== 16'hA57E) begin bad++; $display("FAIL sw_q got=%h exp=a57e", bus.out_q); end
      end
    end
    send_bit(1'b0);
    total += 3;
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL sw_bpsk_valid got=%b exp=1", bus.out_valid); end
    if (bus.out_i !== 16'h7FFF) begin bad++; $display("FAIL sw_bpsk_i got=%h exp=7fff", bus.out_i); end
    if (bus.out_q !== 16'h0000) begin bad++; $display("FAIL sw_bpsk_q got=%h exp=0000", bus.out_q); end
  endtask

  task automatic test_reserved_reset();
    do_reset();
    mode = 2'd3;
    bus.out_ready = 1'b1;
    send_bit(1'b1);
    total++;
    if (mode_err !== 1'b1) begin bad++; $display("FAIL rsvd_err got=%b exp=1", mode_err); end
    send_bit(1'b1);
    total += 4;
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rsvd_valid got=%b exp=1", bus.out_valid); end
    if (bus.out_i !== 16'hA57E) begin bad++; $display("FAIL rsvd_i got=%h exp=a57e", bus.out_i); end
    if (bus.out_q !== 16'hA57E) begin bad++; $display("FAIL rsvd_q got=%h exp=a57e", bus.out_q); end
    if (mode_err !== 1'b0) begin bad++; $display("FAIL rsvd_pulse got=%b exp=0", mode_err); end
    send_bit(1'b0);
    mode = 2'd0;
    rstn = 1'b0;
    #1;
    total += 4;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", bus.out_valid); end
    if (bus.out_i !== 16'h0000) begin bad++; $display("FAIL mid_rst_i got=%h exp=0000", bus.out_i); end
    if (bus.out_q !== 16'h0000) begin bad++; $display("FAIL mid_rst_q got=%h exp=0000", bus.out_q); end
    if (bus.out_last !== 1'b0) begin bad++; $display("FAIL mid_rst_last got=%b exp=0", bus.out_last); end
    @(negedge clk);
    rstn = 1'b1;
    send_bit(1'b1);
    total += 4;
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL fresh_valid got=%b exp=1", bus.out_valid); end
    if (bus.out_i !== 16'h8001) begin bad++; $display("FAIL fresh_i got=%h exp=8001", bus.out_i); end
    if (bus.out_q !== 16'h0000) begin bad++; $display("FAIL fresh_q got=%h exp=0000", bus.out_q); end
    if (mode_err !== 1'b0) begin bad++; $display("FAIL fresh_err got=%b exp=0", mode_err); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_bit = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_qpsk();
    test_bpsk_block();
    test_16qam();
    test_backpressure();
    test_mode_switch();
    test_reserved_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
